tt_um_uabc_scroller: RTL and testbench

//  Parametrised successor to the single-speed 7-seg letter sequencer: scrolls a ROM

---
 rtl/uabc_seg7_pkg.sv | 86 ++++++++
 rtl/uabc_btn_edge.sv | 28 ++
 rtl/tt_um_uabc_scroller.sv | 115 +++++++++++
 tb/tb_tt_um_uabc_scroller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uabc_seg7_pkg.sv
// Character codes, 7-segment glyphs and message ROM for the UABC scroller.
package uabc_seg7_pkg;

    localparam int unsigned CODE_W = 5;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned POS_W  = 5;

    typedef enum logic [CODE_W-1:0] {
        CH_BLANK,
        CH_U,
        CH_A,
        CH_B,
        CH_C,
        CH_DASH,
        CH_E,
        CH_L,
        CH_T,
        CH_R,
        CH_O,
        CH_N,
        CH_I
    } char_t;

    // Segment patterns gfedcba, active-low
    localparam logic [SEG_W-1:0] GLYPH_U     = 7'h41;
    localparam logic [SEG_W-1:0] GLYPH_A     = 7'h08;
    localparam logic [SEG_W-1:0] GLYPH_B     = 7'h03;
    localparam logic [SEG_W-1:0] GLYPH_C     = 7'h46;
    localparam logic [SEG_W-1:0] GLYPH_DASH  = 7'h3F;
    localparam logic [SEG_W-1:0] GLYPH_E     = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_L     = 7'h47;
    localparam logic [SEG_W-1:0] GLYPH_T     = 7'h4E;
    localparam logic [SEG_W-1:0] GLYPH_R     = 7'h2F;
    localparam logic [SEG_W-1:0] GLYPH_O     = 7'h40;
    localparam logic [SEG_W-1:0] GLYPH_N     = 7'h2B;
    localparam logic [SEG_W-1:0] GLYPH_I     = 7'h4F;
    localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'h7F;

    function automatic logic [SEG_W-1:0] glyph(input char_t code);
        logic [SEG_W-1:0] seg;
        seg = GLYPH_BLANK;
        case (code)
            CH_U:    seg = GLYPH_U;
            CH_A:    seg = GLYPH_A;
            CH_B:    seg = GLYPH_B;
            CH_C:    seg = GLYPH_C;
            CH_DASH: seg = GLYPH_DASH;
            CH_E:    seg = GLYPH_E;
            CH_L:    seg = GLYPH_L;
            CH_T:    seg = GLYPH_T;
            CH_R:    seg = GLYPH_R;
            CH_O:    seg = GLYPH_O;
            CH_N:    seg = GLYPH_N;
            CH_I:    seg = GLYPH_I;
            default: seg = GLYPH_BLANK;
        endcase
        return seg;
    endfunction

    // "UABC-ELECTRONICA" at positions 1..16; position 0 is the blank gap
    function automatic char_t msg(input logic [POS_W-1:0] pos);
        char_t code;
        code = CH_BLANK;
        case (pos)
            5'd1:    code = CH_U;
            5'd2:    code = CH_A;
            5'd3:    code = CH_B;
            5'd4:    code = CH_C;
            5'd5:    code = CH_DASH;
            5'd6:    code = CH_E;
            5'd7:    code = CH_L;
            5'd8:    code = CH_E;
            5'd9:    code = CH_C;
            5'd10:   code = CH_T;
            5'd11:   code = CH_R;
            5'd12:   code = CH_O;
            5'd13:   code = CH_N;
            5'd14:   code = CH_I;
            5'd15:   code = CH_C;
            5'd16:   code = CH_A;
            default: code = CH_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/uabc_btn_edge.sv
// Two-flop synchronizer plus edge register; emits one-cycle pulse on a 0->1 input.
module uabc_btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn,
    output logic pulse_c
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else if (ena) begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse_c = sync2 & ~prev;

endmodule

// File: rtl/tt_um_uabc_scroller.sv
// Tiny Tapeout top: scrolls "UABC-ELECTRONICA" on one 7-seg digit with run/pause,
// direction, single-step and four speeds; current position exposed on uio_out.
module tt_um_uabc_scroller
    import uabc_seg7_pkg::*;
#(
    parameter logic [23:0] TICK_DIV = 24'd5_000_000,
    parameter int unsigned MSG_LEN  = 16
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int unsigned CNT_W = 24;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(MSG_LEN);

    logic             run;
    logic             dir;
    logic             pause;
    logic             step_btn;
    logic [1:0]       speed;
    logic             step_pulse_c;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_c;
    logic [CNT_W-1:0] period_m1_c;
    logic             tick_c;

    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] pos_adv_c;

    logic             unused_ok;

    assign run      = ui_in[0];
    assign dir      = ui_in[1];
    assign pause    = ui_in[2];
    assign step_btn = ui_in[3];
    assign speed    = ui_in[5:4];

    assign unused_ok = &{1'b0, ui_in[7:6], uio_in};

    uabc_btn_edge u_step (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .btn     (step_btn),
        .pulse_c (step_pulse_c)
    );

    // Period clamps to 1 at high speeds; '>=' keeps a shortened period from overrunning
    always_comb begin
        period_c    = TICK_DIV >> speed;
        period_m1_c = '0;
        if (period_c != '0) begin
            period_m1_c = period_c - CNT_W'(1);
        end
        tick_c = (cnt >= period_m1_c);
    end

    // Next position in the selected direction, wrapping across the blank gap
    always_comb begin
        pos_adv_c = pos;
        if (dir) begin
            pos_adv_c = (pos == '0) ? LAST_POS : pos - POS_W'(1);
        end else begin
            pos_adv_c = (pos == LAST_POS) ? '0 : pos + POS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ena) begin
            if (!run || tick_c) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Position state: run=0 restarts, pause gates on step only, otherwise prescaler tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= '0;
        end else if (ena) begin
            if (!run) begin
                pos <= '0;
            end else if (pause) begin
                if (step_pulse_c) begin
                    pos <= pos_adv_c;
                end
            end else if (tick_c) begin
                pos <= pos_adv_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_out <= 8'hFF;
        end else if (ena) begin
            uo_out <= {(pos != LAST_POS), glyph(msg(pos))};
        end
    end

    assign uio_out = {3'b000, pos};
    assign uio_oe  = 8'h1F;

endmodule

// File: tb/tb_tt_um_uabc_scroller.sv
// Directed bench for the UABC 7-seg scroller with TICK_DIV=8, MSG_LEN=16.
module tb_tt_um_uabc_scroller;

    typedef struct {
        logic [7:0] ui;
        int         ncyc;
        logic [4:0] pos;
        logic [7:0] uo;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_vec = 0;
    int n_miss = 0;

    logic [7:0] exp_seg [0:16];
    vec_t       vecs[$];

    tt_um_uabc_scroller #(
        .TICK_DIV (24'd8),
        .MSG_LEN  (16)
    ) dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial begin
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %02h expected %02h", name, act, expv);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ui_in = 8'h00;
        ena   = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        edges(1);
    endtask

    task automatic add_vec(input logic [7:0] ui, input int n, input logic [4:0] p,
                           input logic [7:0] uo, input string name);
        vec_t v;
        v.ui = ui; v.ncyc = n; v.pos = p; v.uo = uo; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        exp_seg[0]  = 8'hFF; exp_seg[1]  = 8'hC1; exp_seg[2]  = 8'h88;
        exp_seg[3]  = 8'h83; exp_seg[4]  = 8'hC6; exp_seg[5]  = 8'hBF;
        exp_seg[6]  = 8'h86; exp_seg[7]  = 8'hC7; exp_seg[8]  = 8'h86;
        exp_seg[9]  = 8'hC6; exp_seg[10] = 8'hCE; exp_seg[11] = 8'hAF;
        exp_seg[12] = 8'hC0; exp_seg[13] = 8'hAB; exp_seg[14] = 8'hCF;
        exp_seg[15] = 8'hC6; exp_seg[16] = 8'h08;

        // Forward scroll at speed 0: first step 8 clks after run, glyph one clk later
        add_vec(8'h01, 9, 5'd1, exp_seg[1], "fwd_p1");
        for (int p = 2; p <= 16; p++) begin
            add_vec(8'h01, 8, 5'(p), exp_seg[p], $sformatf("fwd_p%0d", p));
        end
        add_vec(8'h01, 8, 5'd0, exp_seg[0], "fwd_wrap0");
        // Reverse from the blank gap wraps to the last character
        add_vec(8'h03, 8, 5'd16, exp_seg[16], "rev_p16");
        add_vec(8'h03, 8, 5'd15, exp_seg[15], "rev_p15");
        // Speed 3: one step per clk, glyph still lags position by one clk
        add_vec(8'h31, 1, 5'd16, exp_seg[15], "spd3_p16");
        add_vec(8'h31, 1, 5'd0,  exp_seg[16], "spd3_p0");
        add_vec(8'h31, 1, 5'd1,  exp_seg[0],  "spd3_p1");

        // Asynchronous reset with the clock stopped
        #2 rst_n = 1'b0;
        #1;
        chk("rst_uo_out", uo_out, 8'hFF);
        chk("rst_uio_out", uio_out, 8'h00);
        chk("rst_uio_oe", uio_oe, 8'h1F);

        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        edges(1);

        foreach (vecs[i]) begin
            ui_in = vecs[i].ui;
            edges(vecs[i].ncyc);
            chk({vecs[i].name, "_pos"}, uio_out, {3'b000, vecs[i].pos});
            chk({vecs[i].name, "_seg"}, uo_out, vecs[i].uo);
        end

        // Pause with three held step presses: exactly one advance per press
        do_reset();
        ui_in = 8'h05;
        for (int k = 1; k <= 3; k++) begin
            ui_in[3] = 1'b1;
            edges(20);
            ui_in[3] = 1'b0;
            edges(20);
            if (k == 1) chk("step_first", uio_out, 8'd1);
        end
        chk("step_pos3", uio_out, 8'd3);
        chk("step_seg3", uo_out, 8'h83);
        edges(100);
        chk("pause_hold_pos", uio_out, 8'd3);

        // Step while not paused is ignored; tick still lands on schedule
        do_reset();
        ui_in = 8'h09;
        edges(6);
        chk("step_nopause_ign", uio_out, 8'd0);
        edges(2);
        chk("step_nopause_tick", uio_out, 8'd1);

        // Speed 0 -> 3 at cnt=6 ticks on the very next clk
        do_reset();
        ui_in = 8'h01;
        edges(6);
        chk("spdchg_before", uio_out, 8'd0);
        ui_in = 8'h31;
        edges(1);
        chk("spdchg_tick", uio_out, 8'd1);
        edges(1);
        chk("spdchg_next", uio_out, 8'd2);

        // Mid-scroll stop, restart, enable freeze, async reset
        do_reset();
        ui_in = 8'h01;
        edges(56);
        chk("mid_pos7", uio_out, 8'd7);
        edges(1);
        chk("mid_seg7", uo_out, 8'hC7);
        ui_in = 8'h00;
        edges(1);
        chk("stop_pos0", uio_out, 8'd0);
        chk("stop_seg_lag", uo_out, 8'hC7);
        edges(1);
        chk("stop_seg_blank", uo_out, 8'hFF);

        ui_in = 8'h01;
        edges(25);
        chk("restart_pos3", uio_out, 8'd3);
        chk("restart_seg3", uo_out, 8'h83);
        ena   = 1'b0;
        ui_in = 8'h0B;
        edges(50);
        chk("ena0_pos", uio_out, 8'd3);
        chk("ena0_seg", uo_out, 8'h83);
        ena   = 1'b1;
        ui_in = 8'h01;
        edges(6);
        chk("resume_hold", uio_out, 8'd3);
        edges(1);
        chk("resume_tick", uio_out, 8'd4);

        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_uo", uo_out, 8'hFF);
        chk("async_rst_uio", uio_out, 8'h00);
        chk("async_rst_oe", uio_oe, 8'h1F);
        @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
